// File: rtl/line_arbiter.sv
// Round-robin arbiter sharing one downstream cacheline port between an
// instruction-side and a data-side requester. One transaction is in flight
// at a time, and every completion is followed by a one-cycle gap.
module line_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic [ADDR_W-1:0] c_pmem_address,
  output logic [LINE_W-1:0] c_pmem_wdata,
  output logic              c_pmem_read,
  output logic              c_pmem_write,
  input  logic [LINE_W-1:0] c_pmem_rdata,
  input  logic              c_pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    GAP    = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Downstream request payload held for the whole transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic              read;
    logic              write;
  } req_t;

  state_t state_q, state_d;
  grant_t last_grant_q, last_grant_d;
  req_t   req_q, req_d;

  logic   i_req, d_req, pick_i;
  req_t   i_pay, d_pay;

  // Request decode; read+write together is a write.
  always_comb begin
    i_req         = i_pmem_read | i_pmem_write;
    d_req         = d_pmem_read | d_pmem_write;
    pick_i        = i_req & (~d_req | (last_grant_q == GRANT_D));
    i_pay.address = i_pmem_address;
    i_pay.wdata   = i_pmem_wdata;
    i_pay.write   = i_pmem_write;
    i_pay.read    = i_pmem_read & ~i_pmem_write;
    d_pay.address = d_pmem_address;
    d_pay.wdata   = d_pmem_wdata;
    d_pay.write   = d_pmem_write;
    d_pay.read    = d_pmem_read & ~d_pmem_write;
  end

  // State, grant history and latched downstream request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
    end
  end

  // Next-state: grant in IDLE, hold while busy, drop request on completion.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (pick_i) begin
            req_d        = i_pay;
            last_grant_d = GRANT_I;
            state_d      = I_BUSY;
          end else begin
            req_d        = d_pay;
            last_grant_d = GRANT_D;
            state_d      = D_BUSY;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (c_pmem_resp) begin
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
          state_d     = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Downstream outputs come straight from the latched request.
  assign c_pmem_address = req_q.address;
  assign c_pmem_wdata   = req_q.wdata;
  assign c_pmem_read    = req_q.read;
  assign c_pmem_write   = req_q.write;

  // Read data is broadcast; only the completion pulse is steered.
  assign i_pmem_rdata = c_pmem_rdata;
  assign d_pmem_rdata = c_pmem_rdata;
  assign i_pmem_resp  = ~rst & c_pmem_resp & (state_q == I_BUSY);
  assign d_pmem_resp  = ~rst & c_pmem_resp & (state_q == D_BUSY);

endmodule

// File: tb/tb_line_arbiter.sv
// Cycle-by-cycle directed bench for line_arbiter: a table of per-cycle
// inputs and expected outputs, plus hand sequences for reset behaviour.
module tb_line_arbiter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NW     = LINE_W / 32;
  localparam int unsigned NB     = LINE_W / 8;
  localparam int unsigned NV     = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_pmem_address, d_pmem_address, c_pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata, d_pmem_wdata, c_pmem_wdata;
  logic [LINE_W-1:0] i_pmem_rdata, d_pmem_rdata, c_pmem_rdata;
  logic              i_pmem_read, i_pmem_write, i_pmem_resp;
  logic              d_pmem_read, d_pmem_write, d_pmem_resp;
  logic              c_pmem_read, c_pmem_write, c_pmem_resp;

  int checks = 0;
  int errors = 0;

  line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .c_pmem_address(c_pmem_address), .c_pmem_wdata(c_pmem_wdata),
    .c_pmem_read(c_pmem_read), .c_pmem_write(c_pmem_write),
    .c_pmem_rdata(c_pmem_rdata), .c_pmem_resp(c_pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_rd, i_wr;
    logic [31:0] i_a;
    logic        d_rd, d_wr;
    logic [31:0] d_a;
    logic        c_resp;
    logic [7:0]  rb;
    logic        e_rd, e_wr;
    logic [31:0] e_a;
    logic [1:0]  e_key;
    logic        e_ir, e_dr;
  } vec_t;

  vec_t vecs [NV];

  // Write line derived from address and side, so latched wdata is traceable.
  function automatic logic [LINE_W-1:0] wpat(input logic [31:0] a, input logic [1:0] key);
    logic [31:0] w;
    case (key)
      2'd1:    w = a ^ 32'hC0DE_0001;
      2'd2:    w = a ^ 32'hD00D_0002;
      default: w = 32'h0;
    endcase
    return {NW{w}};
  endfunction

  function automatic vec_t mk(
    input logic ir, input logic iw, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da,
    input logic cr, input logic [7:0] rb,
    input logic er, input logic ew, input logic [31:0] ea,
    input logic [1:0] ek, input logic eir, input logic edr);
    vec_t v;
    v.i_rd = ir; v.i_wr = iw; v.i_a = ia;
    v.d_rd = dr; v.d_wr = dw; v.d_a = da;
    v.c_resp = cr; v.rb = rb;
    v.e_rd = er; v.e_wr = ew; v.e_a = ea; v.e_key = ek;
    v.e_ir = eir; v.e_dr = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_pmem_read    = v.i_rd;
    i_pmem_write   = v.i_wr;
    i_pmem_address = v.i_a;
    i_pmem_wdata   = wpat(v.i_a, 2'd1);
    d_pmem_read    = v.d_rd;
    d_pmem_write   = v.d_wr;
    d_pmem_address = v.d_a;
    d_pmem_wdata   = wpat(v.d_a, 2'd2);
    c_pmem_resp    = v.c_resp;
    c_pmem_rdata   = {NB{v.rb}};
  endtask

  initial begin
    logic [LINE_W-1:0] exp_rdata;
    vec_t idle_v;

    // Both sides read/write together, then keep contending: I, D, I, D.
    vecs[0]  = mk(1,0,32'h100,  0,1,32'h2000, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[1]  = mk(1,0,32'h100,  0,1,32'h2000, 0,8'h00, 1,0,32'h100,1,0,0);
    vecs[2]  = mk(1,0,32'h100,  0,1,32'h2000, 1,8'h5A, 1,0,32'h100,1,1,0);
    vecs[3]  = mk(1,0,32'h100,  0,1,32'h2000, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[4]  = mk(1,0,32'h100,  0,1,32'h2000, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[5]  = mk(1,0,32'h100,  0,1,32'h2000, 0,8'h00, 0,1,32'h2000,2,0,0);
    vecs[6]  = mk(1,0,32'h100,  0,1,32'h2000, 1,8'h3C, 0,1,32'h2000,2,0,1);
    vecs[7]  = mk(1,1,32'h140,  1,0,32'h2040, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[8]  = mk(1,1,32'h140,  1,0,32'h2040, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[9]  = mk(1,1,32'h140,  1,0,32'h2040, 1,8'h11, 0,1,32'h140,1,1,0);
    vecs[10] = mk(1,1,32'h140,  1,0,32'h2040, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[11] = mk(1,1,32'h140,  1,0,32'h2040, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[12] = mk(1,1,32'h140,  1,0,32'h2040, 1,8'h22, 1,0,32'h2040,2,0,1);
    vecs[13] = mk(0,0,32'h0,    0,0,32'h0,    0,8'h00, 0,0,32'h0,0,0,0);
    // Stray completion in IDLE.
    vecs[14] = mk(0,0,32'h0,    0,0,32'h0,    1,8'h77, 0,0,32'h0,0,0,0);
    // i-only read, requester drops early, resp after five busy cycles.
    vecs[15] = mk(1,0,32'h1000, 0,0,32'h0,    0,8'h00, 0,0,32'h0,0,0,0);
    vecs[16] = mk(1,0,32'h1000, 0,0,32'h0,    0,8'h00, 1,0,32'h1000,1,0,0);
    vecs[17] = mk(1,0,32'h1000, 0,0,32'h0,    0,8'h00, 1,0,32'h1000,1,0,0);
    vecs[18] = mk(0,0,32'h1000, 0,0,32'h0,    0,8'h00, 1,0,32'h1000,1,0,0);
    vecs[19] = mk(0,0,32'h1000, 0,0,32'h0,    0,8'h00, 1,0,32'h1000,1,0,0);
    vecs[20] = mk(0,0,32'h1000, 0,0,32'h0,    1,8'hA5, 1,0,32'h1000,1,1,0);
    vecs[21] = mk(0,0,32'h0,    0,0,32'h0,    0,8'h00, 0,0,32'h0,0,0,0);
    vecs[22] = mk(0,0,32'h0,    0,0,32'h0,    0,8'h00, 0,0,32'h0,0,0,0);
    // d-side changes address and op mid-transaction; latched values hold.
    vecs[23] = mk(0,0,32'h0,    1,0,32'h3000, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[24] = mk(0,0,32'h0,    1,1,32'h3FC0, 0,8'h00, 1,0,32'h3000,2,0,0);
    vecs[25] = mk(0,0,32'h0,    1,1,32'h3FC0, 0,8'h00, 1,0,32'h3000,2,0,0);
    vecs[26] = mk(0,0,32'h0,    1,1,32'h3FC0, 1,8'h99, 1,0,32'h3000,2,0,1);
    vecs[27] = mk(0,0,32'h0,    1,1,32'h3FC0, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[28] = mk(0,0,32'h0,    1,1,32'h3FC0, 0,8'h00, 0,0,32'h0,0,0,0);
    vecs[29] = mk(0,0,32'h0,    1,1,32'h3FC0, 0,8'h00, 0,1,32'h3FC0,2,0,0);

    idle_v = mk(0,0,32'h0, 0,0,32'h0, 0,8'h00, 0,0,32'h0,0,0,0);

    // Reset with requests and a completion present: everything stays quiet.
    rst = 1'b1;
    drive(mk(1,0,32'h100, 0,1,32'h2000, 1,8'hFF, 0,0,32'h0,0,0,0));
    #3;
    chk("rst.c_rd",    LINE_W'(c_pmem_read), '0);
    chk("rst.c_wr",    LINE_W'(c_pmem_write), '0);
    chk("rst.c_addr",  LINE_W'(c_pmem_address), '0);
    chk("rst.c_wdata", c_pmem_wdata, '0);
    chk("rst.i_resp",  LINE_W'(i_pmem_resp), '0);
    chk("rst.d_resp",  LINE_W'(d_pmem_resp), '0);
    @(negedge clk);
    drive(idle_v);
    rst = 1'b0;

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      exp_rdata = {NB{vecs[i].rb}};
      chk($sformatf("v%0d.c_rd", i),   LINE_W'(c_pmem_read),  LINE_W'(vecs[i].e_rd));
      chk($sformatf("v%0d.c_wr", i),   LINE_W'(c_pmem_write), LINE_W'(vecs[i].e_wr));
      chk($sformatf("v%0d.i_resp", i), LINE_W'(i_pmem_resp),  LINE_W'(vecs[i].e_ir));
      chk($sformatf("v%0d.d_resp", i), LINE_W'(d_pmem_resp),  LINE_W'(vecs[i].e_dr));
      chk($sformatf("v%0d.i_rdata", i), i_pmem_rdata, exp_rdata);
      chk($sformatf("v%0d.d_rdata", i), d_pmem_rdata, exp_rdata);
      if (vecs[i].e_rd || vecs[i].e_wr) begin
        chk($sformatf("v%0d.c_addr", i),  LINE_W'(c_pmem_address), LINE_W'(vecs[i].e_a));
        chk($sformatf("v%0d.c_wdata", i), c_pmem_wdata, wpat(vecs[i].e_a, vecs[i].e_key));
      end
    end

    // Still in D_BUSY with the 0x3FC0 write; assert reset mid-transaction.
    @(negedge clk);
    chk("mr.busy_wr", LINE_W'(c_pmem_write), LINE_W'(1'b1));
    rst = 1'b1;
    #1;
    chk("mr.c_wr",    LINE_W'(c_pmem_write), '0);
    chk("mr.c_rd",    LINE_W'(c_pmem_read), '0);
    chk("mr.c_addr",  LINE_W'(c_pmem_address), '0);
    chk("mr.c_wdata", c_pmem_wdata, '0);
    c_pmem_resp = 1'b1;
    #1;
    chk("mr.d_resp_in_rst", LINE_W'(d_pmem_resp), '0);
    chk("mr.i_resp_in_rst", LINE_W'(i_pmem_resp), '0);
    @(negedge clk);
    drive(idle_v);
    c_pmem_resp = 1'b1;
    rst = 1'b0;
    #1;
    chk("mr.d_resp_late", LINE_W'(d_pmem_resp), '0);
    chk("mr.i_resp_late", LINE_W'(i_pmem_resp), '0);
    // Contention right after reset: i-side must win first.
    @(negedge clk);
    drive(mk(1,0,32'h500, 1,0,32'h600, 0,8'h00, 0,0,32'h0,0,0,0));
    #1;
    chk("mr.idle_rd", LINE_W'(c_pmem_read), '0);
    chk("mr.idle_wr", LINE_W'(c_pmem_write), '0);
    @(negedge clk);
    #1;
    chk("mr.grant_rd",   LINE_W'(c_pmem_read), LINE_W'(1'b1));
    chk("mr.grant_addr", LINE_W'(c_pmem_address), LINE_W'(32'h500));
    c_pmem_resp = 1'b1;
    #1;
    chk("mr.grant_iresp", LINE_W'(i_pmem_resp), LINE_W'(1'b1));
    chk("mr.grant_dresp", LINE_W'(d_pmem_resp), '0);
    @(negedge clk);
    drive(idle_v);
    #1;
    chk("mr.after_rd", LINE_W'(c_pmem_read), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
